// File: rtl/ptw_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ptw_arbiter_pkg
//  Description : Shared state encodings, default widths and helpers for the
//                page-table-walker arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package ptw_arbiter_pkg;

    localparam int c_PTWA_VPN_WIDTH = 20;
    localparam int c_PTWA_PTE_WIDTH = 32;

    typedef enum logic [1:0] {
        PTWA_IDLE   = 2'd0,
        PTWA_ISSUE  = 2'd1,
        PTWA_WAIT   = 2'd2,
        PTWA_RETURN = 2'd3
    } ptwa_state_e;

    function automatic int ptwa_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptw_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : ptw_rr_arbiter
//  Description : Round-robin picker with a priority pointer that advances
//                past the winner on each update strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module ptw_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               update_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic               any_o
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Scan from the pointer upward, wrapping at NUM_REQ; first hit wins.
    always_comb begin
        any_o      = 1'b0;
        grant_id_o = '0;
        grant_o    = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!any_o && req_i[w_idx]) begin
                any_o      = 1'b1;
                grant_id_o = w_idx;
            end
        end
        if (any_o) begin
            grant_o[grant_id_o] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (update_i && any_o) begin
            r_ptr <= (grant_id_o == ID_W'(NUM_REQ-1)) ? '0 : grant_id_o + ID_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ptw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ptw_arbiter
//  Description : Shares one page-table walker between NUM_REQ TLB controllers,
//                one walk outstanding, responses routed back to the owner.
//  Revision    : 1.0  initial release
// ============================================================================
module ptw_arbiter
    import ptw_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int VPN_WIDTH = c_PTWA_VPN_WIDTH,
    parameter int PTE_WIDTH = c_PTWA_PTE_WIDTH,
    localparam int ID_W     = ptwa_id_w(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*VPN_WIDTH-1:0] req_vpn_i,
    output logic [NUM_REQ-1:0]           resp_valid_o,
    input  logic [NUM_REQ-1:0]           resp_ready_i,
    output logic [PTE_WIDTH-1:0]         resp_pte_o,
    output logic                         resp_fault_o,
    output logic                         ptw_req_valid_o,
    input  logic                         ptw_req_ready_i,
    output logic [VPN_WIDTH-1:0]         ptw_req_vpn_o,
    input  logic                         ptw_resp_valid_i,
    output logic                         ptw_resp_ready_o,
    input  logic [PTE_WIDTH-1:0]         ptw_resp_pte_i,
    input  logic                         ptw_resp_fault_i,
    output logic                         busy_o,
    output logic [ID_W-1:0]              grant_id_o
);

    ptwa_state_e           r_state;
    logic [ID_W-1:0]       r_grant_id;
    logic [VPN_WIDTH-1:0]  r_vpn;
    logic [PTE_WIDTH-1:0]  r_pte;
    logic                  r_fault;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_win_id;
    logic                  w_any;
    logic                  w_idle;
    logic                  w_take;
    logic [VPN_WIDTH-1:0]  w_vpn_sel;

    assign w_idle = (r_state == PTWA_IDLE);
    assign w_take = w_idle && w_any;

    ptw_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_valid_i),
        .update_i   (w_take),
        .grant_o    (w_grant),
        .grant_id_o (w_win_id),
        .any_o      (w_any)
    );

    always_comb begin
        w_vpn_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_id == ID_W'(i)) begin
                w_vpn_sel = req_vpn_i[i*VPN_WIDTH +: VPN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= PTWA_IDLE;
            r_grant_id <= '0;
            r_vpn      <= '0;
            r_pte      <= '0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                PTWA_IDLE: begin
                    if (w_any) begin
                        r_vpn      <= w_vpn_sel;
                        r_grant_id <= w_win_id;
                        r_state    <= PTWA_ISSUE;
                    end
                end
                PTWA_ISSUE: begin
                    if (ptw_req_ready_i) begin
                        r_state <= PTWA_WAIT;
                    end
                end
                PTWA_WAIT: begin
                    if (ptw_resp_valid_i) begin
                        r_pte   <= ptw_resp_pte_i;
                        r_fault <= ptw_resp_fault_i;
                        r_state <= PTWA_RETURN;
                    end
                end
                PTWA_RETURN: begin
                    if (resp_ready_i[r_grant_id]) begin
                        r_state <= PTWA_IDLE;
                    end
                end
                default: r_state <= PTWA_IDLE;
            endcase
        end
    end

    // Every output is forced low while rst is asserted, even mid-walk.
    always_comb begin
        req_ready_o      = '0;
        resp_valid_o     = '0;
        resp_pte_o       = '0;
        resp_fault_o     = 1'b0;
        ptw_req_valid_o  = 1'b0;
        ptw_req_vpn_o    = '0;
        ptw_resp_ready_o = 1'b0;
        busy_o           = 1'b0;
        grant_id_o       = '0;
        if (!rst) begin
            req_ready_o      = w_idle ? w_grant : '0;
            resp_pte_o       = r_pte;
            resp_fault_o     = r_fault;
            ptw_req_valid_o  = (r_state == PTWA_ISSUE);
            ptw_req_vpn_o    = r_vpn;
            ptw_resp_ready_o = (r_state == PTWA_WAIT);
            busy_o           = !w_idle;
            grant_id_o       = r_grant_id;
            if (r_state == PTWA_RETURN) begin
                resp_valid_o[r_grant_id] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ptw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ptw_arbiter
//  Description : Directed self-checking bench for ptw_arbiter (2 requesters).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ptw_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int VPN_WIDTH = 20;
    localparam int PTE_WIDTH = 32;

    logic                         clk;
    logic                         rst;
    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic [NUM_REQ*VPN_WIDTH-1:0] req_vpn_i;
    logic [NUM_REQ-1:0]           resp_valid_o;
    logic [NUM_REQ-1:0]           resp_ready_i;
    logic [PTE_WIDTH-1:0]         resp_pte_o;
    logic                         resp_fault_o;
    logic                         ptw_req_valid_o;
    logic                         ptw_req_ready_i;
    logic [VPN_WIDTH-1:0]         ptw_req_vpn_o;
    logic                         ptw_resp_valid_i;
    logic                         ptw_resp_ready_o;
    logic [PTE_WIDTH-1:0]         ptw_resp_pte_i;
    logic                         ptw_resp_fault_i;
    logic                         busy_o;
    logic [0:0]                   grant_id_o;

    int checks;
    int failures;

    ptw_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .VPN_WIDTH (VPN_WIDTH),
        .PTE_WIDTH (PTE_WIDTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_vpn_i        (req_vpn_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_pte_o       (resp_pte_o),
        .resp_fault_o     (resp_fault_o),
        .ptw_req_valid_o  (ptw_req_valid_o),
        .ptw_req_ready_i  (ptw_req_ready_i),
        .ptw_req_vpn_o    (ptw_req_vpn_o),
        .ptw_resp_valid_i (ptw_resp_valid_i),
        .ptw_resp_ready_o (ptw_resp_ready_o),
        .ptw_resp_pte_i   (ptw_resp_pte_i),
        .ptw_resp_fault_i (ptw_resp_fault_i),
        .busy_o           (busy_o),
        .grant_id_o       (grant_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready_o),      64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid_o),     64'd0);
        chk({tag, "_ptw_req_v"},  64'(ptw_req_valid_o),  64'd0);
        chk({tag, "_ptw_resp_r"}, 64'(ptw_resp_ready_o), 64'd0);
        chk({tag, "_busy"},       64'(busy_o),           64'd0);
        chk({tag, "_grant_id"},   64'(grant_id_o),       64'd0);
        chk({tag, "_pte"},        64'(resp_pte_o),       64'd0);
        chk({tag, "_fault"},      64'(resp_fault_o),     64'd0);
        chk({tag, "_vpn"},        64'(ptw_req_vpn_o),    64'd0);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        req_valid_i      = 2'b11;
        req_vpn_i        = '0;
        resp_ready_i     = '0;
        ptw_req_ready_i  = 1'b0;
        ptw_resp_valid_i = 1'b0;
        ptw_resp_pte_i   = '0;
        ptw_resp_fault_i = 1'b0;

        // Reset: outputs low even with requests pending
        tick();
        tick();
        chk_all_zero("reset");
        rst         = 1'b0;
        req_valid_i = 2'b00;

        // Spurious PTW response in IDLE
        ptw_resp_valid_i = 1'b1;
        ptw_resp_pte_i   = 32'hDEADBEEF;
        ptw_resp_fault_i = 1'b1;
        #1;
        chk("spur_ptw_resp_ready", 64'(ptw_resp_ready_o), 64'd0);
        chk("spur_busy", 64'(busy_o), 64'd0);
        tick();
        chk("spur_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("spur_pte_not_latched", 64'(resp_pte_o), 64'd0);
        chk("spur_fault_not_latched", 64'(resp_fault_o), 64'd0);
        ptw_resp_valid_i = 1'b0;
        ptw_resp_fault_i = 1'b0;

        // Single request from requester 0
        req_valid_i = 2'b01;
        req_vpn_i   = {20'h0, 20'h12345};
        #1;
        chk("t1_req_ready", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i     = 2'b00;
        ptw_req_ready_i = 1'b1;
        #1;
        chk("t1_ptw_req_valid", 64'(ptw_req_valid_o), 64'd1);
        chk("t1_ptw_vpn", 64'(ptw_req_vpn_o), 64'h12345);
        chk("t1_busy", 64'(busy_o), 64'd1);
        tick();
        ptw_req_ready_i = 1'b0;
        chk("t1_ptw_resp_ready", 64'(ptw_resp_ready_o), 64'd1);
        chk("t1_ptw_req_dropped", 64'(ptw_req_valid_o), 64'd0);
        tick();
        tick();
        ptw_resp_valid_i = 1'b1;
        ptw_resp_pte_i   = 32'hABCD0001;
        tick();
        ptw_resp_valid_i = 1'b0;
        chk("t1_resp_valid", 64'(resp_valid_o), 64'h1);
        chk("t1_resp_pte", 64'(resp_pte_o), 64'hABCD0001);
        chk("t1_resp_fault", 64'(resp_fault_o), 64'd0);
        chk("t1_grant_id", 64'(grant_id_o), 64'd0);
        resp_ready_i = 2'b01;
        tick();
        resp_ready_i = 2'b00;
        chk("t1_back_idle", 64'(busy_o), 64'd0);
        chk("t1_resp_cleared", 64'(resp_valid_o), 64'd0);

        // Contention from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick();
        rst              = 1'b0;
        req_valid_i      = 2'b11;
        req_vpn_i        = {20'h00002, 20'h00001};
        ptw_req_ready_i  = 1'b1;
        ptw_resp_valid_i = 1'b1;
        resp_ready_i     = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ptw_resp_pte_i = 32'h100 + 32'(k);
            tick();
            chk("t2_vpn", 64'(ptw_req_vpn_o), 64'((k % 2) + 1));
            chk("t2_grant_id", 64'(grant_id_o), 64'(k % 2));
            tick();
            tick();
            chk("t2_resp_valid", 64'(resp_valid_o), ((k % 2) == 1) ? 64'h2 : 64'h1);
            chk("t2_resp_pte", 64'(resp_pte_o), 64'h100 + 64'(k));
            tick();
        end
        ptw_resp_valid_i = 1'b0;
        ptw_req_ready_i  = 1'b0;
        resp_ready_i     = 2'b00;

        // Backpressure on both PTW request and requester-1 response
        req_valid_i = 2'b10;
        req_vpn_i   = {20'h0ABCD, 20'h00001};
        tick();
        req_valid_i = 2'b11;
        for (int k = 0; k < 5; k++) begin
            chk("t3_ptw_req_held", 64'(ptw_req_valid_o), 64'd1);
            chk("t3_vpn_held", 64'(ptw_req_vpn_o), 64'h0ABCD);
            chk("t3_no_ready_issue", 64'(req_ready_o), 64'd0);
            tick();
        end
        ptw_req_ready_i = 1'b1;
        tick();
        ptw_req_ready_i  = 1'b0;
        ptw_resp_valid_i = 1'b1;
        ptw_resp_pte_i   = 32'h55AA55AA;
        tick();
        ptw_resp_valid_i = 1'b0;
        ptw_resp_pte_i   = 32'h11111111;
        resp_ready_i     = 2'b01;
        for (int k = 0; k < 4; k++) begin
            chk("t3_resp_valid_held", 64'(resp_valid_o), 64'h2);
            chk("t3_pte_held", 64'(resp_pte_o), 64'h55AA55AA);
            chk("t3_no_ready_return", 64'(req_ready_o), 64'd0);
            tick();
        end
        resp_ready_i = 2'b10;
        tick();
        resp_ready_i = 2'b00;
        chk("t3_next_ready_rr", 64'(req_ready_o), 64'h1);

        // Fault on requester 1 walk
        req_valid_i = 2'b10;
        req_vpn_i   = {20'h0FFFF, 20'h00001};
        #1;
        chk("t4_req_ready", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i     = 2'b00;
        ptw_req_ready_i = 1'b1;
        tick();
        ptw_req_ready_i  = 1'b0;
        ptw_resp_valid_i = 1'b1;
        ptw_resp_pte_i   = 32'h0;
        ptw_resp_fault_i = 1'b1;
        tick();
        ptw_resp_valid_i = 1'b0;
        ptw_resp_fault_i = 1'b0;
        chk("t4_resp_valid", 64'(resp_valid_o), 64'h2);
        chk("t4_resp_fault", 64'(resp_fault_o), 64'd1);
        chk("t4_resp_pte", 64'(resp_pte_o), 64'd0);
        resp_ready_i = 2'b10;
        tick();
        resp_ready_i = 2'b00;
        chk("t4_done", 64'(busy_o), 64'd0);

        // Reset while waiting for the PTW
        req_valid_i = 2'b01;
        req_vpn_i   = {20'h0, 20'h00777};
        tick();
        req_valid_i     = 2'b00;
        ptw_req_ready_i = 1'b1;
        tick();
        ptw_req_ready_i = 1'b0;
        chk("t5_in_wait", 64'(ptw_resp_ready_o), 64'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("t5_rst_high");
        tick();
        rst              = 1'b0;
        ptw_resp_valid_i = 1'b1;
        ptw_resp_pte_i   = 32'h00000BAD;
        #1;
        chk_all_zero("t5_after_rst");
        tick();
        ptw_resp_valid_i = 1'b0;
        chk("t5_late_resp_ignored", 64'(resp_valid_o), 64'd0);
        chk("t5_late_pte_ignored", 64'(resp_pte_o), 64'd0);
        chk("t5_still_idle", 64'(busy_o), 64'd0);
        req_valid_i = 2'b10;
        req_vpn_i   = {20'h00042, 20'h0};
        #1;
        chk("t5_req_ready", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = 2'b00;
        chk("t5_grant_id", 64'(grant_id_o), 64'd1);
        chk("t5_vpn", 64'(ptw_req_vpn_o), 64'h42);
        chk("t5_ptw_req_valid", 64'(ptw_req_valid_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ptw_arbiter.md
Name: ptw_arbiter

Overview:
Shares one page-table walker (PTW) between NUM_REQ TLB controllers, for example an ITLB and a DTLB.
- Accepts walk requests from the TLB miss paths and grants them round-robin.
- Allows one walk outstanding at a time.
- Returns each PTW response (PTE plus fault) to the requester that issued it.
- Sits between the TLB controllers' PTW handshake ports and the single PTW.

Parameters:
NUM_REQ, 2, number of requesting TLBs (2 to 8)
VPN_WIDTH, 20, virtual page number width
PTE_WIDTH, 32, page table entry width
ID_W (localparam), clog2(NUM_REQ) with minimum 1, requester index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  NUM_REQ  per-requester walk request valid
req_ready_o  out  NUM_REQ  per-requester accept (at most one bit high)
req_vpn_i  in  NUM_REQ*VPN_WIDTH  per-requester VPN; slice i belongs to requester i
resp_valid_o  out  NUM_REQ  per-requester response valid (at most one bit high)
resp_ready_i  in  NUM_REQ  per-requester response ready
resp_pte_o  out  PTE_WIDTH  returned PTE, shared by all requesters
resp_fault_o  out  1  returned walk fault, shared by all requesters
ptw_req_valid_o  out  1  walk request to PTW
ptw_req_ready_i  in  1  PTW accepts request
ptw_req_vpn_o  out  VPN_WIDTH  VPN sent to PTW
ptw_resp_valid_i  in  1  PTW response valid
ptw_resp_ready_o  out  1  arbiter accepts PTW response
ptw_resp_pte_i  in  PTE_WIDTH  PTE from PTW
ptw_resp_fault_i  in  1  walk fault from PTW
busy_o  out  1  high in any state other than IDLE
grant_id_o  out  ID_W  index of the requester currently owning the PTW

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset state: state=IDLE, prio_ptr=0, grant_id=0, latched VPN/PTE/fault=0.
- Reset outputs: all outputs 0 while rst is high, including req_ready_o.
- States: IDLE, ISSUE, WAIT, RETURN. Any illegal encoding goes to IDLE.
- IDLE, arbitration:
  - Winner = first i with req_valid_i[i]=1, scanning from prio_ptr upward and wrapping from NUM_REQ-1 to 0.
  - req_ready_o = one-hot(winner). It is 0 if no request is valid. It is combinational from req_valid_i, which is allowed on the receiver side.
- IDLE, handshake: on req_valid_i[w] & req_ready_o[w]:
  - latch VPN slice w and grant_id=w;
  - prio_ptr <= (w==NUM_REQ-1) ? 0 : w+1;
  - go to ISSUE.
- ISSUE:
  - ptw_req_valid_o=1; ptw_req_vpn_o = latched VPN, held stable until accepted.
  - On ptw_req_ready_i, go to WAIT.
- WAIT:
  - ptw_resp_ready_o=1.
  - On ptw_resp_valid_i, latch PTE and fault, then go to RETURN.
- RETURN:
  - resp_valid_o[grant_id]=1; resp_pte_o and resp_fault_o hold the latched values.
  - On resp_ready_i[grant_id], go to IDLE.
  - resp_ready_i bits of other requesters are ignored.
- Latency:
  - request handshake to ptw_req_valid_o: 1 cycle;
  - PTW response handshake to resp_valid_o: 1 cycle;
  - response handshake to next req_ready_o: 1 cycle.
  - Minimum round trip is 4 cycles plus PTW latency.
- Outputs in non-owning states: req_ready_o=0 outside IDLE; ptw_req_valid_o=0 outside ISSUE; ptw_resp_ready_o=0 outside WAIT; resp_valid_o=0 outside RETURN.
- Withdrawn request: a requester that drops valid before it is granted is simply not granted. No state is kept for it.
- Spurious PTW response: ptw_resp_valid_i outside WAIT is ignored and latches nothing.
- Fault: the fault bit is forwarded unchanged. The PTE is forwarded even on fault.
- Reset mid-walk: on the next cycle the state is IDLE and all outputs are 0. A late PTW response is then ignored because ptw_resp_ready_o=0. The PTW must be reset in the same cycle.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 walks.

Decomposition:
- Shared package: add to tlb_params.vh the state encodings (PTWA_IDLE, PTWA_ISSUE, PTWA_WAIT, PTWA_RETURN) and the default VPN/PTE widths, alongside the existing controller states.
- One sub-module, ptw_rr_arbiter:
  - combinational round-robin picker;
  - prio_ptr register, advanced by an update strobe.
- Top level: FSM, data latches, per-requester response routing.

Test Plan:
1. Single request: req0 VPN 0x12345; ptw_req_ready_i=1; PTW responds 3 cycles later with PTE 0xABCD0001, fault 0.
   -> ptw_req_vpn_o=0x12345 one cycle after the request handshake; resp_valid_o=2'b01, resp_pte_o=0xABCD0001, grant_id_o=0.
2. Contention from reset: req0 VPN 0x00001 and req1 VPN 0x00002 held continuously.
   -> PTW sees 0x00001, 0x00002, 0x00001, 0x00002; grant_id_o alternates 0,1,0,1.
3. Backpressure: ptw_req_ready_i low for 5 cycles, later resp_ready_i[1] low for 4 cycles.
   -> ptw_req_valid_o and VPN held stable; resp_valid_o=2'b10 and PTE held stable; no new req_ready_o during either stall.
4. Fault: req1 walk returns ptw_resp_fault_i=1 with PTE 0x0.
   -> resp_valid_o=2'b10, resp_fault_o=1; requester 0 sees no response.
5. Reset in WAIT: rst pulsed 1 cycle, then ptw_resp_valid_i=1 arrives.
   -> all outputs 0; response ignored; next req1-only request granted normally with grant_id_o=1.
6. Spurious response: ptw_resp_valid_i=1 in IDLE with no requests.
   -> ptw_resp_ready_o=0, resp_valid_o=0, busy_o=0.
